// File: rtl/multicycle_controller.sv
// Multicycle control unit for a reduced RV32I subset (OP / OP-IMM).
// It sequences fetch, decode, execute and writeback, and traps sticky on illegal encodings.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr,
  output logic        ir_load,
  output logic        pc_en,
  output logic        rf_we,
  output logic [4:0]  rd_addr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [31:0] imm,
  output logic        alu_src_imm,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_op, is_opimm, legal, dec_src_imm;
  alu_op_e    dec_op;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7   = ir_q[31:25];
  assign is_opimm = (opcode == 7'b0010011);
  assign is_op    = (opcode == 7'b0110011);

  assign rd_addr  = ir_q[11:7];
  assign rs1_addr = ir_q[19:15];
  assign rs2_addr = ir_q[24:20];
  assign imm      = {{20{ir_q[31]}}, ir_q[31:20]};

  // Shift-immediate forms reuse IR[31:25] as funct7; every other OP-IMM treats it as immediate.
  always_comb begin
    legal = 1'b0;
    if (is_opimm) begin
      legal = 1'b1;
      if (funct3 == 3'b001 && funct7 != 7'b0000000)
        legal = 1'b0;
      if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
        legal = 1'b0;
    end else if (is_op) begin
      legal = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    end
  end

  always_comb begin
    dec_src_imm = is_opimm;
    dec_op      = ALU_ADD;
    unique case (funct3)
      3'b000:  dec_op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  dec_op = ALU_SLL;
      3'b010:  dec_op = ALU_SLT;
      3'b011:  dec_op = ALU_SLTU;
      3'b100:  dec_op = ALU_XOR;
      3'b101:  dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  dec_op = ALU_OR;
      default: dec_op = ALU_AND;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (run_en) state_d = S_FETCH;
      S_FETCH:     if (imem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = run_en ? S_FETCH : S_IDLE;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    rf_we       = 1'b0;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_EXECUTE: begin
        alu_op      = dec_op;
        alu_src_imm = dec_src_imm;
      end
      S_WRITEBACK: begin
        alu_op      = dec_op;
        alu_src_imm = dec_src_imm;
        pc_en       = 1'b1;
        rf_we       = (rd_addr != 5'd0);
      end
      default: ;
    endcase
  end

  assign ir_d      = ir_load ? instr : ir_q;
  assign retired_d = pc_en ? retired_q + 32'd1 : retired_q;
  assign illegal_d = illegal_q | (state_q == S_DECODE && !legal);

  assign retired = retired_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected decode results are queued at issue
// and checked by a monitor when the DUT reaches writeback.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset, run_en, imem_ready;
  logic [31:0] instr;
  logic        imem_req, ir_load, pc_en, rf_we, alu_src_imm, illegal;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] imm, retired;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] immv;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] n_retired = '0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .run_en(run_en), .imem_req(imem_req),
    .imem_ready(imem_ready), .instr(instr), .ir_load(ir_load), .pc_en(pc_en),
    .rf_we(rf_we), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .imm(imm), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .illegal(illegal),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: pops one expectation per retiring instruction.
  always @(negedge clk) begin
    if (pc_en) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wb", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_alu_op", {28'd0, alu_op}, {28'd0, e.op});
        check("wb_src", {31'd0, alu_src_imm}, {31'd0, e.src});
        check("wb_rf_we", {31'd0, rf_we}, {31'd0, e.we});
        check("wb_rd", {27'd0, rd_addr}, {27'd0, e.rd});
        check("wb_imm", imm, e.immv);
        check("wb_retired", retired, e.ret);
        check("wb_state", {29'd0, state}, 32'd4);
      end
    end
  end

  // Expects the DUT to be in FETCH on entry; leaves it in FETCH, or IDLE when drop_run is set.
  task automatic run_instr(input logic [31:0] w, input int unsigned waits, input logic [3:0] op,
                           input logic src, input logic [31:0] immv, input logic drop_run);
    exp_t e;
    e.op = op; e.src = src; e.rd = w[11:7]; e.we = (w[11:7] != 5'd0);
    e.immv = immv; e.ret = n_retired;
    sb_q.push_back(e);
    instr = w;
    for (int i = 0; i < int'(waits); i++) begin
      imem_ready = 1'b0;
      #1;
      check("wait_state", {29'd0, state}, 32'd1);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_irload", {31'd0, ir_load}, 32'd0);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_irload", {31'd0, ir_load}, 32'd1);
    tick();
    instr = 32'hDEAD_BEEF;
    check("decode_state", {29'd0, state}, 32'd2);
    check("decode_req", {31'd0, imem_req}, 32'd0);
    check("decode_irload", {31'd0, ir_load}, 32'd0);
    check("decode_alu_op", {28'd0, alu_op}, 32'd0);
    if (drop_run) run_en = 1'b0;
    tick();
    check("exec_state", {29'd0, state}, 32'd3);
    check("exec_alu_op", {28'd0, alu_op}, {28'd0, op});
    check("exec_src", {31'd0, alu_src_imm}, {31'd0, src});
    check("exec_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    check("wb_state_main", {29'd0, state}, 32'd4);
    n_retired = n_retired + 32'd1;
    tick();
    check("post_retired", retired, n_retired);
    check("post_state", {29'd0, state}, drop_run ? 32'd0 : 32'd1);
    imem_ready = 1'b0;
  endtask

  task automatic do_reset_checks(input string tag);
    check({tag, "_state"}, {29'd0, state}, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_imm"}, imm, 32'd0);
    check({tag, "_outs"}, {26'd0, imem_req, ir_load, pc_en, rf_we, alu_src_imm, |alu_op}, 32'd0);
  endtask

  task automatic trap_seq(input logic [31:0] w);
    instr = w;
    imem_ready = 1'b1;
    tick();
    check("trap_decode", {29'd0, state}, 32'd2);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("trap_state", {29'd0, state}, 32'd5);
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      check("trap_quiet", {28'd0, imem_req, ir_load, pc_en, rf_we}, 32'd0);
      tick();
    end
    check("trap_retired", retired, n_retired);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_retired = '0;
    do_reset_checks("trap_rst");
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b1; imem_ready = 1'b1; instr = 32'h0070_C193;
    repeat (2) tick();
    do_reset_checks("por");
    run_en = 1'b0; reset = 1'b0;
    tick();
    tick();
    check("idle_hold", {29'd0, state}, 32'd0);
    imem_ready = 1'b0;
    run_en = 1'b1;
    tick();
    check("idle_to_fetch", {29'd0, state}, 32'd1);

    run_instr(32'h0780_0293, 0, 4'd0, 1'b1, 32'd120, 1'b0);        // ADDI x5,x0,120
    run_instr(32'h41DF_82B3, 0, 4'd1, 1'b0, 32'h0000_041D, 1'b0);  // SUB x5,x31,x29
    run_instr(32'h01DF_82B3, 0, 4'd0, 1'b0, 32'h0000_001D, 1'b0);  // ADD x5,x31,x29
    run_instr(32'h7FF0_0093, 0, 4'd0, 1'b1, 32'h0000_07FF, 1'b0);  // ADDI x1,x0,2047
    run_instr(32'hFFF0_0113, 0, 4'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);  // ADDI x2,x0,-1
    run_instr(32'h0070_C193, 3, 4'd4, 1'b1, 32'h0000_0007, 1'b0);  // XORI x3,x1,7 with 3 waits
    run_instr(32'h4032_5213, 1, 4'd7, 1'b1, 32'h0000_0403, 1'b0);  // SRAI x4,x4,3
    run_instr(32'h0020_B333, 0, 4'd9, 1'b0, 32'h0000_0002, 1'b0);  // SLTU x6,x1,x2
    run_instr(32'h0020_93B3, 0, 4'd5, 1'b0, 32'h0000_0002, 1'b0);  // SLL x7,x1,x2
    run_instr(32'h0050_0013, 0, 4'd0, 1'b1, 32'h0000_0005, 1'b1);  // ADDI x0,x0,5; drop run_en
    tick();
    check("drop_idle", {29'd0, state}, 32'd0);
    run_en = 1'b1;
    tick();
    check("resume_fetch", {29'd0, state}, 32'd1);

    trap_seq(32'h0000_0000);
    tick();
    check("refetch1", {29'd0, state}, 32'd1);
    trap_seq(32'h4020_F233);  // AND with funct7=0100000
    tick();
    check("refetch2", {29'd0, state}, 32'd1);

    instr = 32'h0780_0293;
    imem_ready = 1'b1;
    tick();
    tick();
    check("pre_rst_exec", {29'd0, state}, 32'd3);
    reset = 1'b1;
    tick();
    do_reset_checks("exec_rst");
    reset = 1'b0;
    run_en = 1'b0;
    tick();
    check("exec_rst_idle", {29'd0, state}, 32'd0);

    check("sb_drain", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports `clk` (input, 1): the single clock; all state changes on its rising edge.
REQ-002 SHALL have port `reset` (input, 1): synchronous, active-high.
REQ-003 SHALL have port `run_en` (input, 1): high permits instruction issue.
REQ-004 SHALL have port `imem_req` (output, 1): instruction fetch request.
REQ-005 SHALL have port `imem_ready` (input, 1): instruction fetch data valid.
REQ-006 SHALL have port `instr` (input, 32): fetched instruction word.
REQ-007 SHALL have port `ir_load` (output, 1): one-cycle pulse when the instruction is captured.
REQ-008 SHALL have port `pc_en` (output, 1): one-cycle pulse; the datapath advances PC by 4.
REQ-009 SHALL have port `rf_we` (output, 1): register-file write enable.
REQ-010 SHALL have ports `rd_addr`, `rs1_addr` and `rs2_addr` (outputs, 5 each): IR[11:7], IR[19:15] and IR[24:20].
REQ-011 SHALL have port `imm` (output, 32): IR[31:20] sign-extended to 32 bits.
REQ-012 SHALL have port `alu_src_imm` (output, 1): 1 selects `imm`, 0 selects rs2.
REQ-013 SHALL have port `alu_op` (output, 4): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-014 SHALL have port `illegal` (output, 1): sticky trap flag.
REQ-015 SHALL have port `retired` (output, 32): count of retired instructions.
REQ-016 SHALL have port `state` (output, 3): IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, TRAP=5.

Function
REQ-017 SHALL hold an internal 32-bit IR that is loaded from `instr` only when `ir_load`=1.
REQ-018 SHALL transition IDLE->FETCH on an edge where `run_en`=1; otherwise it SHALL remain in IDLE.
REQ-019 SHALL assert `imem_req`=1 throughout FETCH and hold it until `imem_ready`=1; `imem_ready` SHALL be ignored in all other states.
REQ-020 SHALL, in a FETCH cycle with `imem_ready`=1, assert `ir_load`=1 and transition to DECODE.
REQ-021 SHALL, in DECODE, classify the IR.
- Legal: opcode 0010011 (OP-IMM), any funct3. For SLLI (funct3=001), IR[31:25] must be 0000000. For SRLI/SRAI (funct3=101), IR[31:25] must be 0000000 or 0100000.
- Legal: opcode 0110011 (OP) with funct7=0000000, or with funct7=0100000 only when funct3 is 000 or 101.
- Anything else: illegal; DECODE->TRAP.
- Legal: DECODE->EXECUTE.
REQ-022 SHALL drive `alu_op` and `alu_src_imm` valid in EXECUTE and WRITEBACK; both SHALL be 0 in all other states.
- `alu_src_imm` = 1 for OP-IMM.
- Mapping: funct3 000 -> ADD, or SUB when OP with funct7[5]=1. 111 -> AND; 110 -> OR; 100 -> XOR; 001 -> SLL; 101 -> SRL, or SRA when funct7[5]=1; 010 -> SLT; 011 -> SLTU.
- ADDI SHALL never decode as SUB.
REQ-023 SHALL transition EXECUTE->WRITEBACK unconditionally.
REQ-024 SHALL, in WRITEBACK:
- assert `rf_we`=1 only if `rd_addr`!=0;
- assert `pc_en`=1;
- increment `retired` by 1, wrapping 0xFFFFFFFF->0;
- go to FETCH if `run_en`=1, else IDLE.
REQ-025 SHALL give a latency of 4 cycles per instruction when `imem_ready` is high on the first FETCH cycle, plus 1 cycle per wait cycle.
REQ-026 SHALL, on `run_en` deasserting mid-instruction, complete the current instruction through WRITEBACK and then enter IDLE.
REQ-027 SHALL, in TRAP, set `illegal`=1 and hold `imem_req`, `ir_load`, `pc_en` and `rf_we` at 0; the state SHALL remain TRAP until `reset`, and `retired` SHALL not increment.
REQ-028 SHALL drive `rd_addr`, `rs1_addr`, `rs2_addr` and `imm` from the IR in every state.

Reset
REQ-029 SHALL, on the edge where `reset`=1 in any state (including mid-FETCH wait or TRAP), enter IDLE and clear IR, `retired` and `illegal` to 0.
REQ-030 SHALL hold every output at 0 while in reset and in IDLE, except that `rd_addr`, `rs1_addr`, `rs2_addr` and `imm` track the IR, which is 0 after reset.
REQ-031 SHALL give `reset` priority over `run_en` and `imem_ready` on the same edge.

Verification
REQ-032 SHALL be verified with a zero-wait memory (`imem_ready`=1) executing ADDI x5,x0,120: states 1,2,3,4 on consecutive cycles; `rd_addr`=5; `imm`=120; `alu_op`=0; `alu_src_imm`=1; `rf_we`=1 and `pc_en`=1 only in WRITEBACK; `retired`=1.
REQ-033 SHALL be verified with SUB x5,x31,x29 followed by ADD x5,x31,x29: `alu_op` 1 then 0; `alu_src_imm`=0; ADDI imm=2047 yields `alu_op`=0 and `imm`=0x000007FF; ADDI imm=0xFFF yields `imm`=0xFFFFFFFF.
REQ-034 SHALL be verified with `imem_ready` low for 3 FETCH cycles: `imem_req` stays high 4 cycles; `ir_load` pulses once; the instruction takes 7 cycles.
REQ-035 SHALL be verified with instr=0x00000000 or funct7=0100000 on AND: `state`=5 and `illegal`=1 hold for 10 cycles with no `pc_en`/`rf_we`; then `reset`=1 gives IDLE, `illegal`=0, `retired`=0.
REQ-036 SHALL be verified with ADDI x0,x0,5: `rf_we`=0 while `pc_en`=1 and `retired` increments.
REQ-037 SHALL be verified by dropping `run_en` during DECODE: WRITEBACK still retires, then `state`=0; also `reset` asserted during EXECUTE: `state`=0 on the next edge with all outputs 0.
